// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// pipeline_hazard_ctrl_pkg : shared state encoding, widths and control words
// Rev 1.0
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    MDBUSY = 1'b1
  } md_state_t;

  localparam int MD_CNT_W = 6;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
  // NOP controls into ID/EX while IF/ID and the PC hold
  localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hilo_busy_timer.sv
// ============================================================================
// hilo_busy_timer : RUN/MDBUSY FSM with down-counter tracking HI/LO occupancy
// Rev 1.0
// ============================================================================
`default_nettype none

module hilo_busy_timer
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int LATENCY = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic last
);

  md_state_t             state;
  logic [MD_CNT_W-1:0]   md_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (start) begin
            state  <= MDBUSY;
            md_cnt <= MD_CNT_W'(LATENCY - 1);
          end
        end
        MDBUSY: begin
          if (md_cnt == '0) state <= RUN;
          else              md_cnt <= md_cnt - 1'b1;
        end
        default: begin
          state  <= RUN;
          md_cnt <= '0;
        end
      endcase
    end
  end

  assign busy = (state == MDBUSY);
  assign last = busy && (md_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : load-use / HI-LO stall and branch flush control
// Optional perf counters enabled by HAZARD_PERF_CNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UsesRt,
  input  logic        ID_MulDiv,
  input  logic        ID_ReadsHiLo,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_WriteRegister,
  input  logic        EX_BranchTaken,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount,
`endif
  output logic        MD_Busy
);

  logic  busy;
  logic  last;
  logic  load_use_hazard;
  logic  hilo_hazard;
  logic  stall;
  logic  md_start;
  ctrl_t ctrl;

  assign load_use_hazard = EX_MemRead && (EX_WriteRegister != 5'd0) &&
                           ((EX_WriteRegister == ID_rs) ||
                            (ID_UsesRt && (EX_WriteRegister == ID_rt)));

  // The final busy cycle (last) still blocks; the waiting op issues next RUN cycle
  assign hilo_hazard = (busy || last) && (ID_MulDiv || ID_ReadsHiLo);
  assign stall       = (load_use_hazard || hilo_hazard) && !EX_BranchTaken;
  assign md_start    = ID_MulDiv && !busy && !stall && !EX_BranchTaken;

  always_comb begin
    ctrl = CTRL_RUN;
    if (EX_BranchTaken) ctrl = CTRL_FLUSH;
    else if (stall)     ctrl = CTRL_STALL;
  end

  assign PC_Write    = ctrl.pc_write;
  assign IFID_Write  = ctrl.ifid_write;
  assign IFID_Flush  = ctrl.ifid_flush;
  assign IDEX_Bubble = ctrl.idex_bubble;
  assign MD_Busy     = busy;

  hilo_busy_timer #(
    .LATENCY (MD_LATENCY)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .busy  (busy),
    .last  (last)
  );

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stall && (StallCount != 16'hFFFF))          StallCount <= StallCount + 16'd1;
      if (EX_BranchTaken && (FlushCount != 16'hFFFF)) FlushCount <= FlushCount + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl : directed vectors with hand-computed control words
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_rs, ID_rt, EX_WriteRegister;
  logic       ID_UsesRt, ID_MulDiv, ID_ReadsHiLo, EX_MemRead, EX_BranchTaken;
  logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, MD_Busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] StallCount, FlushCount;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, MD_Busy}
  localparam logic [4:0] E_RUN   = 5'b11000;
  localparam logic [4:0] E_STALL = 5'b00010;
  localparam logic [4:0] E_FLUSH = 5'b11110;
  localparam logic [4:0] E_RUNB  = 5'b11001;
  localparam logic [4:0] E_STLB  = 5'b00011;
  localparam logic [4:0] E_FLSB  = 5'b11111;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_LATENCY(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .ID_rs            (ID_rs),
    .ID_rt            (ID_rt),
    .ID_UsesRt        (ID_UsesRt),
    .ID_MulDiv        (ID_MulDiv),
    .ID_ReadsHiLo     (ID_ReadsHiLo),
    .EX_MemRead       (EX_MemRead),
    .EX_WriteRegister (EX_WriteRegister),
    .EX_BranchTaken   (EX_BranchTaken),
    .PC_Write         (PC_Write),
    .IFID_Write       (IFID_Write),
    .IFID_Flush       (IFID_Flush),
    .IDEX_Bubble      (IDEX_Bubble),
`ifdef HAZARD_PERF_CNT_EN
    .StallCount       (StallCount),
    .FlushCount       (FlushCount),
`endif
    .MD_Busy          (MD_Busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    #2;
    check_val(tag, {27'd0, PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, MD_Busy}, {27'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_rs = 5'd1; ID_rt = 5'd2; ID_UsesRt = 1'b0; ID_MulDiv = 1'b0; ID_ReadsHiLo = 1'b0;
    EX_MemRead = 1'b0; EX_WriteRegister = 5'd3; EX_BranchTaken = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_ctl("reset", E_RUN);

    // load-use on rs, then released
    EX_MemRead = 1'b1; EX_WriteRegister = 5'd8; ID_rs = 5'd8;
    chk_ctl("lu_rs", E_STALL);
    tick(); EX_MemRead = 1'b0;
    chk_ctl("lu_release", E_RUN);

    // rt match counts only when rt is a source
    idle(); EX_MemRead = 1'b1; EX_WriteRegister = 5'd9; ID_rt = 5'd9; ID_UsesRt = 1'b1;
    chk_ctl("lu_rt", E_STALL);
    ID_UsesRt = 1'b0;
    chk_ctl("lu_rt_unused", E_RUN);

    idle(); EX_MemRead = 1'b1; EX_WriteRegister = 5'd0; ID_rs = 5'd0;
    chk_ctl("lu_r0", E_RUN);

    // flush beats stall; a flushed muldiv is not accepted
    idle(); EX_MemRead = 1'b1; EX_WriteRegister = 5'd8; ID_rs = 5'd8; EX_BranchTaken = 1'b1; ID_MulDiv = 1'b1;
    chk_ctl("flush_prio", E_FLUSH);
    tick(); idle();
    chk_ctl("flushed_md", E_RUN);

    // MULT accepted, MFLO waits 4 cycles and issues on the 5th
    ID_MulDiv = 1'b1;
    chk_ctl("mult_acc", E_RUN);
    tick(); ID_MulDiv = 1'b0; ID_ReadsHiLo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_ctl($sformatf("mflo_wait%0d", i), E_STLB);
      tick();
    end
    chk_ctl("mflo_issue", E_RUN);

    // branch in MDBUSY does not cancel; waiting muldiv issues after drain
    idle(); ID_MulDiv = 1'b1;
    tick(); idle(); EX_BranchTaken = 1'b1;              // cnt=3
    chk_ctl("br_busy", E_FLSB);
    tick(); idle();                                     // cnt=2
    chk_ctl("busy_kept", E_RUNB);
    ID_MulDiv = 1'b1;
    for (int i = 0; i < 3; i++) begin                   // cnt=2,1,0
      chk_ctl($sformatf("md_wait%0d", i), E_STLB);
      tick();
    end
    chk_ctl("md_reissue", E_RUN);
    tick(); ID_MulDiv = 1'b0;                           // cnt=3
    chk_ctl("md_busy2", E_RUNB);

    // reset at md_cnt=2 abandons the op
    tick(); ID_ReadsHiLo = 1'b1; reset = 1'b1;          // cnt=2
    chk_ctl("pre_reset", E_STLB);
    tick(); reset = 1'b0;
    chk_ctl("mfhi_after_reset", E_RUN);

`ifdef HAZARD_PERF_CNT_EN
    idle(); reset = 1'b1; tick(); reset = 1'b0;
    check_val("stall_cnt_rst", {16'd0, StallCount}, 32'd0);
    check_val("flush_cnt_rst", {16'd0, FlushCount}, 32'd0);
    EX_MemRead = 1'b1; EX_WriteRegister = 5'd8; ID_rs = 5'd8;
    tick(); tick();
    EX_BranchTaken = 1'b1; tick(); idle();
    check_val("stall_cnt", {16'd0, StallCount}, 32'd2);
    check_val("flush_cnt", {16'd0, FlushCount}, 32'd1);
    EX_MemRead = 1'b1; EX_WriteRegister = 5'd8; ID_rs = 5'd8;
    repeat (65532) @(posedge clk);
    #1;
    check_val("stall_fffe", {16'd0, StallCount}, 32'h0000FFFE);
    tick(); tick(); tick();
    check_val("stall_sat", {16'd0, StallCount}, 32'h0000FFFF);
    idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 32: cycles a multiply/divide occupies the HI/LO unit; legal range 2..63.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ID_rs, input, 5: rs field of the instruction in ID.
REQ-005 SHALL have port ID_rt, input, 5: rt field of the instruction in ID.
REQ-006 SHALL have port ID_UsesRt, input, 1: the ID instruction reads rt as a source.
REQ-007 SHALL have port ID_MulDiv, input, 1: the ID instruction is MULT/MULTU/DIV/DIVU.
REQ-008 SHALL have port ID_ReadsHiLo, input, 1: the ID instruction is MFHI/MFLO.
REQ-009 SHALL have port EX_MemRead, input, 1: the EX instruction is a load.
REQ-010 SHALL have port EX_WriteRegister, input, 5: destination register of the EX instruction.
REQ-011 SHALL have port EX_BranchTaken, input, 1: branch/jump resolved taken in EX.
REQ-012 SHALL have port PC_Write, output, 1: PC update enable.
REQ-013 SHALL have port IFID_Write, output, 1: IF/ID register write enable.
REQ-014 SHALL have port IFID_Flush, output, 1: clear IF/ID to a NOP.
REQ-015 SHALL have port IDEX_Bubble, output, 1: load NOP controls into ID/EX.
REQ-016 SHALL have port MD_Busy, output, 1: HI/LO unit occupied.

Function
REQ-017 SHALL implement states RUN and MDBUSY, plus a 6-bit down-counter md_cnt.
REQ-018 Load-use hazard SHALL be asserted when EX_MemRead=1, EX_WriteRegister!=0, and EX_WriteRegister==ID_rs or (ID_UsesRt=1 and EX_WriteRegister==ID_rt).
REQ-019 HiLo hazard SHALL be asserted when state=MDBUSY and ID_MulDiv=1 or ID_ReadsHiLo=1.
REQ-020 Stall SHALL be asserted when either hazard is asserted and EX_BranchTaken=0; the outputs are then PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0.
REQ-021 When EX_BranchTaken=1, the outputs SHALL be IFID_Flush=1, IDEX_Bubble=1, PC_Write=1, IFID_Write=1; the flush has priority over any stall.
REQ-022 When neither stall nor flush is asserted, the outputs SHALL be PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0.
REQ-023 All four pipeline-control outputs SHALL be combinational functions of the current state and inputs, with zero latency.
REQ-024 A muldiv SHALL be accepted when state=RUN, ID_MulDiv=1, no stall and EX_BranchTaken=0; the next state is MDBUSY with md_cnt=MD_LATENCY-1.
REQ-025 In MDBUSY, md_cnt SHALL decrement each cycle; when md_cnt=0 the next state is RUN. The muldiv occupies exactly MD_LATENCY cycles of MD_Busy=1.
REQ-026 A muldiv in ID that is flushed or stalled SHALL NOT be accepted. A taken branch during MDBUSY SHALL NOT cancel the in-flight operation.
REQ-027 A muldiv waiting in ID while md_cnt=0 SHALL stall that cycle, then be accepted in the following RUN cycle; there is no back-to-back overlap.
REQ-028 MD_Busy SHALL be 1 exactly when state=MDBUSY.

Reset
REQ-029 When reset=1 at a clock edge, the next state SHALL be RUN, md_cnt=0 and perf counters=0. This also applies mid-operation, which abandons the muldiv.
REQ-030 While in RUN after reset, the outputs SHALL follow REQ-018..022: PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0, MD_Busy=0 absent hazards.

Configuration
REQ-031 When HAZARD_PERF_CNT_EN is defined, the block SHALL add outputs StallCount[15:0] and FlushCount[15:0].
- StallCount increments on every stall cycle; FlushCount increments on every EX_BranchTaken cycle.
- Both saturate at 16'hFFFF and clear on reset.
REQ-032 When HAZARD_PERF_CNT_EN is undefined, those ports and registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 A shared package SHALL hold the state encoding (RUN=1'b0, MDBUSY=1'b1), the MD_CNT_W=6 width and the NOP control constant.
REQ-034 The counter/FSM SHALL be a sub-module hilo_busy_timer (inputs start, clk, reset; outputs busy, last). The hazard decode SHALL remain in the top module.

Verification
REQ-035 Load r8, EX_WriteRegister=8, ID_rs=8 -> one cycle PC_Write=0, IFID_Write=0, IDEX_Bubble=1; next cycle, with EX_MemRead=0, normal flow.
REQ-036 EX_MemRead=1, EX_WriteRegister=0, ID_rs=0 -> no stall. Same with ID_rt match and ID_UsesRt=0 -> no stall.
REQ-037 Load-use hazard and EX_BranchTaken=1 in the same cycle -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1.
REQ-038 With MD_LATENCY=4: MULT accepted, then MFLO in ID next -> MD_Busy high 4 cycles, MFLO stalled 4 cycles and issues on the 5th.
REQ-039 Reset asserted at md_cnt=2 -> next cycle MD_Busy=0 and a waiting MFHI issues. A saturation test preloads StallCount at 16'hFFFE, then 3 stalls -> 16'hFFFF.
